hub75_capture: RTL and testbench

- HUB75 sink: samples the six colour lines, CLK_HUB75, LATCH, OE and ROWSEL that our panel driver emits.
- Rebuilds per-pixel on-time and stores it as saturating per-channel counters in block RAM.
- Exposes the counters on the standard CPU bus slave port, so firmware and benches can check PWM duty, row order and frame rate against the framebuffer contents.
- Sits on the same bus as the driver. Typical use is a loopback of the driver outputs on the same clock.

---
 rtl/hub75_capture.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_hub75_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// hub75_capture: HUB75 sink that rebuilds per-pixel on-time from the panel
// driver's shift/latch stream and accumulates it into saturating per-channel
// counters in two block RAMs (top/bottom half), readable over the CPU bus.
module hub75_capture #(
  parameter int          ROWS     = 64,
  parameter int          COLS     = 64,
  parameter int          CNT_BITS = 10,
  parameter logic [31:0] BASEADDR = 32'h8200_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic [3:0]                wmask,
  input  logic                      wen,
  input  logic                      ren,
  output logic [31:0]               rdata,
  output logic                      ready,
  output logic                      active,
  input  logic                      R0,
  input  logic                      G0,
  input  logic                      B0,
  input  logic                      R1,
  input  logic                      G1,
  input  logic                      B1,
  input  logic [$clog2(ROWS/2)-1:0] ROWSEL,
  input  logic                      CLK_HUB75,
  input  logic                      LATCH,
  input  logic                      OE
);
  localparam int RW    = $clog2(ROWS/2);
  localparam int HALF  = (ROWS/2)*COLS;
  localparam int NPIX  = ROWS*COLS;
  localparam int IDX_W = $clog2(HALF);
  localparam int CW    = $clog2(COLS);
  localparam int SCW   = $clog2(COLS+1);
  localparam int DW    = 3*CNT_BITS;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_CLEAR = 2'd3} state_e;

  // Adds one to each channel whose colour bit is set, holding at full scale
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] word, input logic [2:0] bits);
    logic [CNT_BITS-1:0] c;
    sat_add = word;
    for (int k = 0; k < 3; k++) begin
      c = word[k*CNT_BITS +: CNT_BITS];
      if (bits[k] && (c != {CNT_BITS{1'b1}})) begin
        c = c + CNT_BITS'(1'b1);
      end else begin
        c = c;
      end
      sat_add[k*CNT_BITS +: CNT_BITS] = c;
    end
  endfunction

  // input stage
  logic [5:0]    colour_q, colour_d;
  logic          ck_q, ck_d, ck_prev_q, ck_prev_d;
  logic          lt_q, lt_d, lt_prev_q, lt_prev_d;
  logic [RW-1:0] rowsel_q, rowsel_d;
  logic          oe_q, oe_d;
  // capture
  logic [5:0]     slot_q [COLS];
  logic [5:0]     slot_d [COLS];
  logic [5:0]     snap_q [COLS];
  logic [5:0]     snap_d [COLS];
  logic [SCW-1:0] shift_cnt_q, shift_cnt_d;
  logic [RW-1:0]  latched_row_q, latched_row_d;
  logic [15:0]    latch_count_q, latch_count_d;
  logic           overrun_q, overrun_d, col_ovf_q, col_ovf_d;
  // update FSM
  state_e          state_q, state_d, fsm_next_s;
  logic [CW-1:0]   col_q, col_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  // bus
  logic          pend_q, pend_d, pend_bot_q, pend_bot_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  // RAM
  logic [DW-1:0]    top_mem [HALF];
  logic [DW-1:0]    bot_mem [HALF];
  logic [DW-1:0]    top_rd_q, bot_rd_q, top_wdata_s, bot_wdata_s;
  logic [IDX_W-1:0] rd_idx_s, wr_idx_s, pix_idx_s, bus_idx_s;
  logic             mem_we_s;
  // decode
  logic [31:0] off_s, status_s;
  logic [29:0] word_s;
  logic        is_status_s, bus_ok_s, clear_req_s;
  logic        ck_rise_s, lt_rise_s, lt_accept_s;
  logic        unused_s;

  assign off_s       = addr - BASEADDR;
  assign word_s      = off_s[31:2];
  assign active      = (word_s <= 30'(NPIX));
  assign is_status_s = (word_s == 30'(NPIX));
  assign bus_idx_s   = (word_s >= 30'(HALF)) ? IDX_W'(word_s - 30'(HALF)) : IDX_W'(word_s);
  assign pix_idx_s   = IDX_W'(latched_row_q) * IDX_W'(COLS) + IDX_W'(col_q);
  assign bus_ok_s    = active && !ready_q && !pend_q;
  assign clear_req_s = wen && bus_ok_s && is_status_s && wmask[0] && wdata[0];
  assign ck_rise_s   = ck_q && !ck_prev_q;
  assign lt_rise_s   = lt_q && !lt_prev_q;
  assign lt_accept_s = lt_rise_s && (state_q == S_IDLE);
  assign status_s    = {13'd0, col_ovf_q, overrun_q, (state_q != S_IDLE), latch_count_q};
  assign rdata       = rdata_q;
  assign ready       = ready_q && active;
  assign unused_s    = ^{off_s[1:0], wdata[31:1], wmask[3:1], oe_q};

  // Register stage for all HUB75 inputs plus previous copies for edge detection
  always_comb begin
    colour_d  = {B1, G1, R1, B0, G0, R0};
    ck_d      = CLK_HUB75;
    ck_prev_d = ck_q;
    lt_d      = LATCH;
    lt_prev_d = lt_q;
    rowsel_d  = ROWSEL;
    oe_d      = OE;
  end

  // Shift-slot capture, latch snapshot, latch counter and sticky flags
  always_comb begin
    slot_d        = slot_q;
    snap_d        = snap_q;
    shift_cnt_d   = shift_cnt_q;
    latched_row_d = latched_row_q;
    latch_count_d = latch_count_q;
    overrun_d     = overrun_q;
    col_ovf_d     = col_ovf_q;
    if (ck_rise_s) begin
      if (shift_cnt_q == SCW'(COLS)) begin
        col_ovf_d = 1'b1;
      end else begin
        slot_d[shift_cnt_q[CW-1:0]] = colour_q;
        shift_cnt_d = shift_cnt_q + SCW'(1'b1);
      end
    end else begin
      shift_cnt_d = shift_cnt_q;
    end
    // slot_d already holds any same-cycle shift, so the snapshot includes it
    if (lt_rise_s) begin
      shift_cnt_d   = {SCW{1'b0}};
      latch_count_d = latch_count_q + 16'd1;
      if (state_q == S_IDLE) begin
        snap_d        = slot_d;
        latched_row_d = rowsel_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      latch_count_d = latch_count_q;
    end
    if (clear_req_s) begin
      latch_count_d = 16'd0;
      overrun_d     = 1'b0;
      col_ovf_d     = 1'b0;
    end else begin
      col_ovf_d = col_ovf_d;
    end
  end

  // Update/clear FSM: RAM addressing, read-modify-write data and sequencing
  always_comb begin
    fsm_next_s  = state_q;
    col_d       = col_q;
    clr_idx_d   = clr_idx_q;
    rd_idx_s    = bus_idx_s;
    wr_idx_s    = pix_idx_s;
    mem_we_s    = 1'b0;
    top_wdata_s = {DW{1'b0}};
    bot_wdata_s = {DW{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (lt_accept_s) begin
          fsm_next_s = S_RD;
          col_d      = {CW{1'b0}};
        end else begin
          fsm_next_s = S_IDLE;
        end
      end
      S_RD: begin
        rd_idx_s   = pix_idx_s;
        fsm_next_s = S_WR;
      end
      S_WR: begin
        mem_we_s    = 1'b1;
        top_wdata_s = sat_add(top_rd_q, snap_q[col_q][2:0]);
        bot_wdata_s = sat_add(bot_rd_q, snap_q[col_q][5:3]);
        if (col_q == CW'(COLS-1)) begin
          fsm_next_s = S_IDLE;
        end else begin
          col_d      = col_q + CW'(1'b1);
          fsm_next_s = S_RD;
        end
      end
      S_CLEAR: begin
        mem_we_s = 1'b1;
        wr_idx_s = clr_idx_q;
        if (clr_idx_q == IDX_W'(HALF-1)) begin
          fsm_next_s = S_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1'b1);
        end
      end
      default: fsm_next_s = S_IDLE;
    endcase
    // a clear command aborts whatever is in flight
    state_d = clear_req_s ? S_CLEAR : fsm_next_s;
    clr_idx_d = clear_req_s ? {IDX_W{1'b0}} : clr_idx_d;
  end

  // Bus handshake: reads only in IDLE (RAM words take an extra clk), writes acked
  always_comb begin
    pend_d     = 1'b0;
    pend_bot_d = pend_bot_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    if (pend_q) begin
      rdata_d = 32'(pend_bot_q ? bot_rd_q : top_rd_q);
      ready_d = 1'b1;
    end else if (bus_ok_s && wen) begin
      ready_d = 1'b1;
    end else if (bus_ok_s && ren && (state_q == S_IDLE)) begin
      if (is_status_s) begin
        rdata_d = status_s;
        ready_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_bot_d = (word_s >= 30'(HALF));
      end
    end else begin
      ready_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      colour_q      <= 6'd0;
      ck_q          <= 1'b0;
      ck_prev_q     <= 1'b0;
      lt_q          <= 1'b0;
      lt_prev_q     <= 1'b0;
      rowsel_q      <= {RW{1'b0}};
      oe_q          <= 1'b1;
      for (int i = 0; i < COLS; i++) begin
        slot_q[i] <= 6'd0;
        snap_q[i] <= 6'd0;
      end
      shift_cnt_q   <= {SCW{1'b0}};
      latched_row_q <= {RW{1'b0}};
      latch_count_q <= 16'd0;
      overrun_q     <= 1'b0;
      col_ovf_q     <= 1'b0;
      state_q       <= S_IDLE;
      col_q         <= {CW{1'b0}};
      clr_idx_q     <= {IDX_W{1'b0}};
      pend_q        <= 1'b0;
      pend_bot_q    <= 1'b0;
      rdata_q       <= 32'd0;
      ready_q       <= 1'b0;
    end else begin
      colour_q      <= colour_d;
      ck_q          <= ck_d;
      ck_prev_q     <= ck_prev_d;
      lt_q          <= lt_d;
      lt_prev_q     <= lt_prev_d;
      rowsel_q      <= rowsel_d;
      oe_q          <= oe_d;
      slot_q        <= slot_d;
      snap_q        <= snap_d;
      shift_cnt_q   <= shift_cnt_d;
      latched_row_q <= latched_row_d;
      latch_count_q <= latch_count_d;
      overrun_q     <= overrun_d;
      col_ovf_q     <= col_ovf_d;
      state_q       <= state_d;
      col_q         <= col_d;
      clr_idx_q     <= clr_idx_d;
      pend_q        <= pend_d;
      pend_bot_q    <= pend_bot_d;
      rdata_q       <= rdata_d;
      ready_q       <= ready_d;
    end
  end

  // Counter RAMs: synchronous read, one shared write index for both halves
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      top_mem[wr_idx_s] <= top_wdata_s;
      bot_mem[wr_idx_s] <= bot_wdata_s;
    end
    top_rd_q <= top_mem[rd_idx_s];
    bot_rd_q <= bot_mem[rd_idx_s];
  end

endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: directed + randomized HUB75 stimulus against a
// per-pixel counting model of the capture block.
module tb_hub75_capture;
  localparam int ROWS = 4, COLS = 4, CNT_BITS = 10;
  localparam int RSW = $clog2(ROWS/2);
  localparam int NPIX = ROWS*COLS;
  localparam int CMAX = (1 << CNT_BITS) - 1;
  localparam logic [31:0] BASE = 32'h8200_0000;
  localparam logic [31:0] STATUS_ADDR = BASE + 32'(4*NPIX);

  logic clk = 1'b0, rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] wmask;
  logic wen, ren, ready, active;
  logic R0, G0, B0, R1, G1, B1, CLK_HUB75, LATCH, OE;
  logic [RSW-1:0] ROWSEL;

  hub75_capture #(.ROWS(ROWS), .COLS(COLS), .CNT_BITS(CNT_BITS), .BASEADDR(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask), .wen(wen),
    .ren(ren), .rdata(rdata), .ready(ready), .active(active),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .ROWSEL(ROWSEL), .CLK_HUB75(CLK_HUB75), .LATCH(LATCH), .OE(OE));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  // model: m_cnt[panel row][col][channel R,G,B]
  int m_cnt [ROWS][COLS][3];
  logic [5:0] m_slot [COLS];
  int m_sc, m_lc;
  bit m_ovr, m_cov;
  logic [31:0] rd_data;
  bit rd_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    int r, c;
    r = w / COLS;
    c = w % COLS;
    return 32'(m_cnt[r][c][0]) | (32'(m_cnt[r][c][1]) << CNT_BITS) |
           (32'(m_cnt[r][c][2]) << (2*CNT_BITS));
  endfunction

  function automatic logic [31:0] exp_status();
    return {13'd0, m_cov, m_ovr, 1'b0, 16'(m_lc)};
  endfunction

  task automatic m_clear();
    foreach (m_cnt[r, c, k]) m_cnt[r][c][k] = 0;
    m_lc = 0;
    m_ovr = 1'b0;
    m_cov = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [5:0] b);
    if (m_sc < COLS) begin
      m_slot[m_sc] = b;
      m_sc++;
    end else begin
      m_cov = 1'b1;
    end
    {B1, G1, R1, B0, G0, R0} = b;
    CLK_HUB75 = 1'b1;
    @(negedge clk);
    CLK_HUB75 = 1'b0;
    @(negedge clk);
  endtask

  // accepted: whether the capture block is expected to be idle at this latch
  task automatic latch_row(input int row, input bit accepted);
    m_lc = (m_lc + 1) % 65536;
    m_sc = 0;
    if (!accepted) begin
      m_ovr = 1'b1;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        for (int k = 0; k < 3; k++) begin
          if (m_slot[c][k]) m_cnt[row][c][k] = (m_cnt[row][c][k] < CMAX) ? m_cnt[row][c][k] + 1 : CMAX;
          if (m_slot[c][3+k]) m_cnt[row+ROWS/2][c][k] =
              (m_cnt[row+ROWS/2][c][k] < CMAX) ? m_cnt[row+ROWS/2][c][k] + 1 : CMAX;
        end
      end
    end
    ROWSEL = RSW'(row);
    LATCH = 1'b1;
    @(negedge clk);
    LATCH = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output bit ok);
    ok = 1'b0;
    d = 32'd0;
    addr = a;
    ren = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        d = rdata;
        ok = 1'b1;
        break;
      end
    end
    ren = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output bit ok);
    ok = 1'b0;
    addr = a;
    wdata = d;
    wmask = m;
    wen = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    wen = 1'b0;
  endtask

  task automatic do_clear();
    bus_write(STATUS_ADDR, 32'h1, 4'h1, rd_ok);
    check("clear_ack", 32'(rd_ok), 32'd1);
    m_clear();
  endtask

  task automatic compare_all(input string tag);
    for (int w = 0; w <= NPIX; w++) begin
      bus_read(BASE + 32'(4*w), rd_data, rd_ok);
      check($sformatf("%s_ack%0d", tag, w), 32'(rd_ok), 32'd1);
      check($sformatf("%s_w%0d", tag, w), rd_data, (w == NPIX) ? exp_status() : exp_word(w));
    end
  endtask

  task automatic read_check(input string tag, input int w, input logic [31:0] exp);
    bus_read(BASE + 32'(4*w), rd_data, rd_ok);
    check(tag, rd_data, exp);
  endtask

  initial begin
    {B1, G1, R1, B0, G0, R0} = 6'd0;
    CLK_HUB75 = 1'b0; LATCH = 1'b0; OE = 1'b1; ROWSEL = '0;
    addr = 32'd0; wdata = 32'd0; wmask = 4'd0; wen = 1'b0; ren = 1'b0;
    rst = 1'b1;
    m_sc = 0;
    foreach (m_slot[i]) m_slot[i] = 6'd0;
    m_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    bus_read(STATUS_ADDR, rd_data, rd_ok);
    check("rst_status", rd_data, 32'd0);

    // clear -> everything zero
    do_clear();
    compare_all("clr0");

    // directed row: G1 at col 0, R0 at col 2, latched into row 1
    shift_bits(6'h10); shift_bits(6'h00); shift_bits(6'h01); shift_bits(6'h00);
    latch_row(1, 1'b1);
    idle(2*COLS + 2);
    read_check("dir_w6", 6, 32'h001);
    read_check("dir_w12", 12, 32'h400);
    read_check("dir_status", NPIX, 32'h1);
    compare_all("dir");

    // pixel writes are acked and ignored; STATUS write without wmask[0] does not clear
    bus_write(BASE + 32'(4*6), 32'hFFFF_FFFF, 4'hF, rd_ok);
    check("pixw_ack", 32'(rd_ok), 32'd1);
    read_check("pixw_w6", 6, exp_word(6));
    bus_write(STATUS_ADDR, 32'h1, 4'hE, rd_ok);
    check("nomask_ack", 32'(rd_ok), 32'd1);
    read_check("nomask_status", NPIX, exp_status());

    // address window boundaries
    addr = STATUS_ADDR + 32'd4;
    ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("oob_ready", 32'(ready), 32'd0);
      check("oob_active", 32'(active), 32'd0);
    end
    ren = 1'b0;
    addr = BASE - 32'd4;
    @(negedge clk);
    check("below_active", 32'(active), 32'd0);
    addr = STATUS_ADDR;
    @(negedge clk);
    check("status_active", 32'(active), 32'd1);
    addr = BASE;
    @(negedge clk);
    check("base_active", 32'(active), 32'd1);

    // overrun: second latch 3 clks after the first is dropped
    do_clear();
    for (int c = 0; c < COLS; c++) shift_bits(6'($urandom));
    latch_row(0, 1'b1);
    idle(1);
    latch_row(1, 1'b0);
    idle(2*COLS + 2);
    read_check("ovr_status", NPIX, 32'h0002_0002);
    compare_all("ovr");

    // column overflow: fifth shift dropped
    do_clear();
    for (int c = 0; c < COLS + 1; c++) shift_bits(6'($urandom));
    latch_row(1, 1'b1);
    idle(2*COLS + 2);
    read_check("cov_status", NPIX, 32'h0004_0001);
    compare_all("cov");

    // clear issued while an update is in flight
    for (int c = 0; c < COLS; c++) shift_bits(6'h3F);
    latch_row(0, 1'b1);
    do_clear();
    compare_all("midclr");

    // saturation: 1028 full-on latches of row 0
    for (int n = 0; n < 1028; n++) begin
      for (int c = 0; c < COLS; c++) shift_bits(6'h3F);
      latch_row(0, 1'b1);
      idle(2);
    end
    idle(2*COLS + 2);
    read_check("sat_w0", 0, 32'h3FFF_FFFF);
    read_check("sat_status", NPIX, 32'd1028);
    compare_all("sat");

    // randomized rows, occasionally short or overlong
    do_clear();
    for (int n = 0; n < 40; n++) begin
      int ncol;
      ncol = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, COLS + 1)) : COLS;
      for (int c = 0; c < ncol; c++) shift_bits(6'($urandom));
      latch_row(int'($urandom_range(0, ROWS/2 - 1)), 1'b1);
      idle(2*COLS + 2 + int'($urandom_range(0, 3)));
    end
    compare_all("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
